prog_clk_divider: RTL and testbench

- Runtime-programmable, parametrised clock divider and tick generator.
- Generalises the fixed-ratio divider in four ways:
  - the divide ratio can be reloaded while running, without glitches;
  - it has a one-shot (timer) mode alongside continuous mode;
  - it produces an approximately 50%-duty divided clock-enable waveform as well as the tick;
  - it exposes its count.
- Feeds tick enables to counters and display-scan logic, and acts as a programmable delay timer.

---
 rtl/prog_clk_divider_if.sv | 27 ++
 rtl/prog_clk_divider.sv | 109 ++++++++++
 tb/tb_prog_clk_divider.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_clk_divider_if.sv
// Control/status bundle for prog_clk_divider: ratio programming, mode/start/pause in; tick, clk_out, count out.
// Ports: pause, mode, start, div_value, div_load (driven by master); tick, clk_out, busy, count, cfg_err (driven by slave).
// No flow control: every input is sampled on each rising clk edge, outputs are valid every cycle.
interface prog_clk_divider_if #(
  parameter int WIDTH = 16
);
  logic             pause;
  logic             mode;
  logic             start;
  logic [WIDTH-1:0] div_value;
  logic             div_load;
  logic             tick;
  logic             clk_out;
  logic             busy;
  logic [WIDTH-1:0] count;
  logic             cfg_err;

  modport master (
    output pause, mode, start, div_value, div_load,
    input  tick, clk_out, busy, count, cfg_err
  );

  modport slave (
    input  pause, mode, start, div_value, div_load,
    output tick, clk_out, busy, count, cfg_err
  );
endinterface

// File: rtl/prog_clk_divider.sv
// Programmable clock divider / tick generator with continuous and one-shot modes.
// Latency: tick, clk_out, count and cfg_err are registered (one cycle after the deciding edge); busy is combinational.
// No backpressure; pause freezes the counter, ratio loads while busy wait for the next terminal count.
// Ports: clk, reset (async, active high); bus (slave modport) carries control inputs and status outputs.
module prog_clk_divider #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input logic               clk,
  input logic               reset,
  prog_clk_divider_if.slave bus
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] div_active;
  logic [WIDTH-1:0] div_pend;
  logic             pend_valid;
  logic             running;
  logic             tick_q;
  logic             clk_out_q;
  logic             cfg_err_q;

  logic             busy;
  logic             en;
  logic             term;
  logic             load_ok;
  logic             load_zero;
  logic [WIDTH:0]   half_div;

  // Continuous mode is always busy; one-shot is busy only while a run is in flight.
  assign busy      = running | ~bus.mode;
  assign en        = busy & ~bus.pause;
  assign term      = (count_q == div_active - WIDTH'(1));
  assign load_zero = bus.div_load & (bus.div_value == '0);
  assign load_ok   = bus.div_load & (bus.div_value != '0);

  // ceil(N/2), one bit wider so N = 2^WIDTH-1 does not overflow.
  assign half_div  = ({1'b0, div_active} + (WIDTH+1)'(1)) >> 1;

  always_comb begin
    count_d = count_q;
    if (en & term) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      tick_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      running    <= 1'b0;
      div_active <= DIV_RST;
      div_pend   <= DIV_RST;
      pend_valid <= 1'b0;
    end else begin
      count_q   <= count_d;
      tick_q    <= en & term;
      cfg_err_q <= load_zero;

      // Waveform is derived from the count it will show next, so it lines up with count.
      if (en) begin
        clk_out_q <= ({1'b0, count_d} < half_div);
      end

      // Pending ratio takes effect only at a period boundary, so periods are never truncated.
      if (en & term & pend_valid) begin
        div_active <= div_pend;
        pend_valid <= 1'b0;
      end

      // Keeping running set in continuous mode lets a 0->1 mode switch finish the current period.
      if (!bus.mode) begin
        running <= 1'b1;
      end else if (en & term) begin
        running <= 1'b0;
      end

      // Placed after the terminal swap: a load on the terminal edge becomes the next pending value.
      if (load_ok) begin
        if (busy) begin
          div_pend   <= bus.div_value;
          pend_valid <= 1'b1;
        end else begin
          div_active <= bus.div_value;
        end
      end

      // Start is only honoured while idle, so en is low here and nothing else moves count.
      if (bus.mode & ~running & bus.start) begin
        running <= 1'b1;
        count_q <= '0;
      end
    end
  end

  assign bus.tick    = tick_q;
  assign bus.clk_out = clk_out_q;
  assign bus.busy    = busy;
  assign bus.count   = count_q;
  assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
module tb_prog_clk_divider;
  localparam int W    = 4;
  localparam int DDIV = 10;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   cyc;

  prog_clk_divider_if #(.WIDTH(W)) bus ();

  prog_clk_divider #(.WIDTH(W), .DEFAULT_DIV(DDIV)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Reference model: position within the period, ratio, pending ratio (0 = none), run flag.
  int m_count, m_n, m_pend;
  bit m_run, m_tick, m_clk, m_err;

  task automatic model_reset();
    m_count = 0; m_n = DDIV; m_pend = 0;
    m_run = 0; m_tick = 0; m_clk = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit busy_m, en_m, wrap, run0;
    int nxt;
    run0   = m_run;
    busy_m = m_run || (bus.mode == 1'b0);
    en_m   = busy_m && !bus.pause;
    wrap   = en_m && (m_count == m_n - 1);
    nxt    = en_m ? (m_count + 1) % m_n : m_count;
    if (en_m) m_clk = (2 * nxt < m_n);
    m_tick = wrap;
    m_err  = bus.div_load && (bus.div_value == 0);
    if (wrap && m_pend != 0) begin
      m_n = m_pend;
      m_pend = 0;
    end
    if (bus.mode == 1'b0) m_run = 1;
    else if (wrap) m_run = 0;
    if (bus.div_load && bus.div_value != 0) begin
      if (busy_m) m_pend = int'(bus.div_value);
      else m_n = int'(bus.div_value);
    end
    if (bus.mode && !run0 && bus.start) begin
      m_run = 1;
      nxt = 0;
    end
    m_count = nxt;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("count",   int'(bus.count),   m_count);
    chk("tick",    int'(bus.tick),    int'(m_tick));
    chk("clk_out", int'(bus.clk_out), int'(m_clk));
    chk("busy",    int'(bus.busy),    int'(m_run || (bus.mode == 1'b0)));
    chk("cfg_err", int'(bus.cfg_err), int'(m_err));
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic wait_tick(input int max);
    int waited;
    waited = 0;
    do begin
      step_cycle();
      waited++;
    end while (bus.tick !== 1'b1 && waited < max);
    if (bus.tick !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL tick_wait: got no tick expected tick within %0d cycles", max);
    end
  endtask

  // Called at a negedge; checks that outputs clear without any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_count",   int'(bus.count),   0);
    chk("rst_tick",    int'(bus.tick),    0);
    chk("rst_clk_out", int'(bus.clk_out), 0);
    chk("rst_cfg_err", int'(bus.cfg_err), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_in(input logic p, input logic m, input logic s, input int dv, input logic dl);
    bus.pause = p; bus.mode = m; bus.start = s; bus.div_value = W'(dv); bus.div_load = dl;
  endtask

  typedef struct {
    logic p, m, s;
    int   dv;
    logic dl;
    int   cnt;
    logic tk, co, bz, er;
  } vec_t;

  function automatic vec_t mk(input logic p, input int dv, input logic dl,
                              input int cnt, input logic tk, input logic co, input logic er);
    vec_t v;
    v.p = p; v.m = 1'b0; v.s = 1'b0; v.dv = dv; v.dl = dl;
    v.cnt = cnt; v.tk = tk; v.co = co; v.bz = 1'b1; v.er = er;
    return v;
  endfunction

  vec_t tv[21];

  initial begin
    int t0, hi, seen, maxc, guard;
    n_tests = 0; n_fail = 0; cyc = 0;
    set_in(0, 0, 0, 0, 0);

    // Continuous N=10, load 4 mid-period, zero load, pause across a tick boundary.
    tv[0]  = mk(0, 0, 0, 1, 0, 1, 0);
    tv[1]  = mk(0, 0, 0, 2, 0, 1, 0);
    tv[2]  = mk(0, 4, 1, 3, 0, 1, 0);
    tv[3]  = mk(0, 0, 0, 4, 0, 1, 0);
    tv[4]  = mk(0, 0, 0, 5, 0, 0, 0);
    tv[5]  = mk(0, 0, 0, 6, 0, 0, 0);
    tv[6]  = mk(0, 0, 0, 7, 0, 0, 0);
    tv[7]  = mk(0, 0, 0, 8, 0, 0, 0);
    tv[8]  = mk(0, 0, 0, 9, 0, 0, 0);
    tv[9]  = mk(0, 0, 0, 0, 1, 1, 0);
    tv[10] = mk(0, 0, 0, 1, 0, 1, 0);
    tv[11] = mk(0, 0, 0, 2, 0, 0, 0);
    tv[12] = mk(0, 0, 0, 3, 0, 0, 0);
    tv[13] = mk(0, 0, 0, 0, 1, 1, 0);
    tv[14] = mk(0, 0, 1, 1, 0, 1, 1);
    tv[15] = mk(0, 0, 0, 2, 0, 0, 0);
    tv[16] = mk(0, 0, 0, 3, 0, 0, 0);
    tv[17] = mk(0, 0, 0, 0, 1, 1, 0);
    tv[18] = mk(1, 0, 0, 0, 0, 1, 0);
    tv[19] = mk(1, 0, 0, 0, 0, 1, 0);
    tv[20] = mk(0, 0, 0, 1, 0, 1, 0);

    model_reset();
    do_reset();

    for (int i = 0; i < 21; i++) begin
      set_in(tv[i].p, tv[i].m, tv[i].s, tv[i].dv, tv[i].dl);
      step_cycle();
      chk($sformatf("tv%0d_count", i),   int'(bus.count),   tv[i].cnt);
      chk($sformatf("tv%0d_tick", i),    int'(bus.tick),    int'(tv[i].tk));
      chk($sformatf("tv%0d_clk_out", i), int'(bus.clk_out), int'(tv[i].co));
      chk($sformatf("tv%0d_busy", i),    int'(bus.busy),    int'(tv[i].bz));
      chk($sformatf("tv%0d_cfg_err", i), int'(bus.cfg_err), int'(tv[i].er));
    end
    set_in(0, 0, 0, 0, 0);

    // N=7: 4 high / 3 low, then a 5-cycle pause at count 2 stretches the period to 12.
    set_in(0, 0, 0, 7, 1);
    step_cycle();
    set_in(0, 0, 0, 0, 0);
    wait_tick(20);
    hi = int'(bus.clk_out);
    for (int i = 1; i < 7; i++) begin
      step_cycle();
      hi += int'(bus.clk_out);
    end
    chk("n7_clk_high", hi, 4);
    step_cycle();
    chk("n7_tick", int'(bus.tick), 1);
    t0 = cyc;
    step_cycle();
    step_cycle();
    chk("pause_start_count", int'(bus.count), 2);
    bus.pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      chk("paused_count", int'(bus.count), 2);
      chk("paused_tick", int'(bus.tick), 0);
    end
    bus.pause = 1'b0;
    wait_tick(20);
    chk("pause_interval", cyc - t0, 12);

    // One-shot: switching mode finishes the current period, then idle.
    bus.mode = 1'b1;
    wait_tick(20);
    chk("mode_switch_busy_in_tick", int'(bus.busy), 0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      seen += int'(bus.tick);
    end
    chk("idle_no_tick", seen, 0);
    set_in(0, 1, 0, 6, 1);
    step_cycle();
    chk("idle_load_busy", int'(bus.busy), 0);
    set_in(0, 1, 1, 0, 0);
    step_cycle();
    bus.start = 1'b0;
    t0 = cyc;
    chk("oneshot_busy", int'(bus.busy), 1);
    step_cycle();
    step_cycle();
    bus.start = 1'b1;
    step_cycle();
    bus.start = 1'b0;
    wait_tick(20);
    chk("oneshot_len", cyc - t0, 6);
    chk("oneshot_busy_in_tick", int'(bus.busy), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step_cycle();
      seen += int'(bus.tick);
    end
    chk("oneshot_no_retick", seen, 0);
    bus.start = 1'b1;
    step_cycle();
    bus.start = 1'b0;
    t0 = cyc;
    wait_tick(20);
    chk("oneshot_repeat_len", cyc - t0, 6);
    set_in(0, 1, 1, 3, 1);
    step_cycle();
    set_in(0, 1, 0, 0, 0);
    t0 = cyc;
    wait_tick(20);
    chk("oneshot_start_load_len", cyc - t0, 3);

    // N=1: tick every cycle, clk_out constant high.
    set_in(0, 0, 0, 1, 1);
    step_cycle();
    set_in(0, 0, 0, 0, 0);
    wait_tick(10);
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      chk("n1_tick", int'(bus.tick), 1);
      chk("n1_clk_out", int'(bus.clk_out), 1);
    end

    // N=15 (maximum for WIDTH=4): 15-cycle period, count tops out at 14.
    set_in(0, 0, 0, 15, 1);
    step_cycle();
    set_in(0, 0, 0, 0, 0);
    wait_tick(10);
    t0 = cyc;
    maxc = 0;
    guard = 0;
    do begin
      step_cycle();
      guard++;
      if (int'(bus.count) > maxc) maxc = int'(bus.count);
    end while (bus.tick !== 1'b1 && guard < 40);
    chk("n15_interval", cyc - t0, 15);
    chk("n15_max_count", maxc, 14);

    // Async reset at count 5 with a load pending: pending value must be lost.
    set_in(0, 0, 0, 3, 1);
    step_cycle();
    set_in(0, 0, 0, 0, 0);
    guard = 0;
    while (int'(bus.count) != 5 && guard < 40) begin
      step_cycle();
      guard++;
    end
    chk("pre_reset_count", int'(bus.count), 5);
    do_reset();
    t0 = cyc;
    wait_tick(20);
    chk("post_reset_interval", cyc - t0, DDIV);
    t0 = cyc;
    wait_tick(20);
    chk("post_reset_no_pend", cyc - t0, DDIV);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.pause = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) bus.mode = ~bus.mode;
      bus.start = ($urandom_range(0, 5) == 0);
      bus.div_load = ($urandom_range(0, 7) == 0);
      bus.div_value = W'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) do_reset();
      else step_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
